// File: rtl/medidor_periodo_128hz_if.sv
// rtl/medidor_periodo_128hz_if.sv - measured-signal and result bundle for the period meter
//
// Purpose: groups the slow input wave and the measurement results of
// medidor_periodo_128hz into one bundle.
// Ports (signals):
//    sig_in        asynchronous slow square wave to be measured
//    period        last measured period in clk cycles (CNT_W bits)
//    period_valid  one-cycle pulse when period is updated
//    in_range      period within EXPECTED +/- TOL
//    timeout       level, no edge seen for MAX_PERIOD cycles
//    locked        periods are being reported
// Modports: master = the meter (drives results), slave = the consumer.
interface medidor_periodo_128hz_if #(
   parameter int CNT_W = 20
);
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             in_range;
   logic             timeout;
   logic             locked;

   modport master (
      input  sig_in,
      output period, period_valid, in_range, timeout, locked
   );

   modport slave (
      output sig_in,
      input  period, period_valid, in_range, timeout, locked
   );
endinterface

// File: rtl/medidor_periodo_128hz.sv
// rtl/medidor_periodo_128hz.sv - period meter for the divided 128 Hz timing tick
//
// Purpose: synchronises a slow square wave, detects its rising edges, counts
// clk cycles between consecutive edges, flags tolerance and loss of signal.
// Ports:
//    clk    system clock (50 MHz), single clock domain
//    reset  synchronous, active-low
//    bus    medidor_periodo_128hz_if.master: sig_in in; period, period_valid,
//           in_range, timeout, locked out
module medidor_periodo_128hz #(
   parameter int CNT_W      = 20,
   parameter int EXPECTED   = 390625,
   parameter int TOL        = 64,
   parameter int MAX_PERIOD = 1048575
) (
   input  logic                    clk,
   input  logic                    reset,
   medidor_periodo_128hz_if.master bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam logic        [CNT_W-1:0] MAX_C = CNT_W'(MAX_PERIOD);
   localparam logic signed [CNT_W:0]   EXP_S = (CNT_W+1)'(EXPECTED);
   localparam logic signed [CNT_W:0]   TOL_S = (CNT_W+1)'(TOL);

   state_t           state;
   state_t           state_nx;
   logic             s1, s2, s3;
   logic             edge_det;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period_q;
   logic             valid_q;
   logic             in_range_q;
   logic             timeout_q;
   logic             at_max;
   logic signed [CNT_W:0] diff;
   logic             cnt_ok;

   // Two-flop synchroniser plus history flop; sig_in is used nowhere else.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_det = s2 & ~s3;
   assign at_max   = (cnt == MAX_C);

   // One extra bit so cnt - EXPECTED cannot overflow for any CNT_W-bit count.
   assign diff   = $signed({1'b0, cnt}) - EXP_S;
   assign cnt_ok = (diff <= TOL_S) && (diff >= -TOL_S);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; an edge in the same cycle as the count limit wins.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (edge_det) state_nx = ARM;
         end
         ARM, MEASURE: begin
            if (edge_det)    state_nx = MEASURE;
            else if (at_max) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.locked = (state == MEASURE);
   end

   // Counter and registered results
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt        <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         in_range_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               // cnt is already 0 here; timeout keeps its value until a real period
               if (edge_det) cnt <= CNT_W'(1);
            end
            default: begin
               if (edge_det) begin
                  period_q   <= cnt;
                  in_range_q <= cnt_ok;
                  valid_q    <= 1'b1;
                  timeout_q  <= 1'b0;
                  cnt        <= CNT_W'(1);
               end else if (at_max) begin
                  timeout_q  <= 1'b1;
                  in_range_q <= 1'b0;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.period       = period_q;
   assign bus.period_valid = valid_q;
   assign bus.in_range     = in_range_q;
   assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_medidor_periodo_128hz.sv
// tb/tb_medidor_periodo_128hz.sv - scoreboard bench for medidor_periodo_128hz
module tb_medidor_periodo_128hz;

   localparam int CNT_W      = 20;
   localparam int EXPECTED   = 1000;
   localparam int TOL        = 4;
   localparam int MAX_PERIOD = 4000;
   localparam int HIGH       = 300;

   typedef struct {
      longint t;
      int     p;
      bit     ir;
   } exp_t;

   logic   clk   = 1'b0;
   logic   reset = 1'b0;
   longint cyc   = 0;

   int checks   = 0;
   int failures = 0;

   exp_t   exp_q[$];
   longint exp_to[$];
   longint obs_to[$];

   // reference model state (stimulus side)
   bit     armed    = 1'b0;
   longint last_eff = 0;
   longint last_neg = 0;
   bit     async_mode = 1'b0;
   bit     mon_en   = 1'b0;
   int     rst_evt  = 0;

   // monitor-private state
   bit     prev_valid = 1'b0;
   bit     prev_to    = 1'b0;
   int     mon_last_period = 0;
   int     seen_rst = 0;

   medidor_periodo_128hz_if #(.CNT_W(CNT_W)) bus ();

   medidor_periodo_128hz #(
      .CNT_W(CNT_W), .EXPECTED(EXPECTED), .TOL(TOL), .MAX_PERIOD(MAX_PERIOD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc > 80000) begin
         $display("FAIL watchdog actual=%0d cycles required<=80000", cyc);
         $fatal(1, "watchdog expired");
      end
   end

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: a rise sampled at count n. Periods are differences of
   // consecutive rise counts; a gap beyond MAX_PERIOD means a timeout and re-arm.
   task automatic model_rise(input longint n);
      exp_t   e;
      longint gap;
      longint dev;
      if (!armed) begin
         armed    = 1'b1;
         last_eff = n;
      end else begin
         gap = n - last_eff;
         if (gap <= MAX_PERIOD) begin
            dev  = (gap > EXPECTED) ? gap - EXPECTED : EXPECTED - gap;
            e.t  = n + 3;
            e.p  = int'(gap);
            e.ir = (dev <= TOL);
            exp_q.push_back(e);
         end else begin
            exp_to.push_back(last_eff + 3 + MAX_PERIOD);
         end
         last_eff = n;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (cyc >= last_neg + HIGH) bus.sig_in = 1'b0;
      end
   endtask

   // Next rise 'gap' negedges after the previous one; optional sub-cycle jitter.
   task automatic rise(input int gap, input bit jit);
      int     d;
      longint n;
      while (cyc < last_neg + gap) begin
         @(negedge clk);
         if (cyc >= last_neg + HIGH) bus.sig_in = 1'b0;
      end
      n        = cyc;
      last_neg = cyc;
      d        = 0;
      if (jit) begin
         d = int'($urandom_range(0, 18));
         if (d >= 10) d++;
      end
      #(d);
      bus.sig_in = 1'b1;
      model_rise(n + ((d > 10) ? 1 : 0));
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst_evt != seen_rst) begin
         seen_rst        = rst_evt;
         mon_last_period = 0;
      end
      if (mon_en) begin
         if (exp_q.size() > 0 && cyc > exp_q[0].t) begin
            e = exp_q.pop_front();
            check("missing_valid", 0, e.t);
         end
         if (bus.period_valid) begin
            check("valid_width", prev_valid, 0);
            if (exp_q.size() == 0) begin
               check("spurious_valid", bus.period, -1);
            end else begin
               e = exp_q.pop_front();
               check("valid_time", cyc, e.t);
               check("period", bus.period, e.p);
               check("in_range", bus.in_range, e.ir);
               check("locked_on_valid", bus.locked, 1);
               check("timeout_clear", bus.timeout, 0);
               mon_last_period = e.p;
               if (async_mode)
                  check("async_period_set", (bus.period >= 999 && bus.period <= 1001), 1);
            end
         end
         if (bus.timeout && !prev_to) begin
            obs_to.push_back(cyc);
            check("timeout_locked", bus.locked, 0);
            check("timeout_in_range", bus.in_range, 0);
            check("timeout_period_hold", bus.period, mon_last_period);
         end
         if (!bus.timeout && prev_to && !bus.period_valid)
            check("timeout_drop_without_valid", 1, 0);
         prev_valid = bus.period_valid;
         prev_to    = bus.timeout;
      end
   end

   initial begin
      int tol_gaps[4] = '{996, 1004, 995, 1005};
      bus.sig_in = 1'b0;
      reset      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_period", bus.period, 0);
      check("rst_valid", bus.period_valid, 0);
      check("rst_in_range", bus.in_range, 0);
      check("rst_timeout", bus.timeout, 0);
      check("rst_locked", bus.locked, 0);
      reset    = 1'b1;
      mon_en   = 1'b1;
      last_neg = cyc;

      // steady 1000-cycle wave
      rise(5, 1'b0);
      repeat (6) rise(1000, 1'b0);

      // tolerance boundaries
      foreach (tol_gaps[i]) rise(tol_gaps[i], 1'b0);

      // loss of signal, then restart
      rise(4500, 1'b0);
      rise(1000, 1'b0);
      rise(1000, 1'b0);

      // edge coincident with the count limit, then one cycle beyond it
      rise(MAX_PERIOD, 1'b0);
      rise(MAX_PERIOD + 1, 1'b0);
      rise(1000, 1'b0);
      rise(1000, 1'b0);

      // reset mid-measurement while locked
      idle_cycles(10);
      check("locked_before_reset", bus.locked, 1);
      idle_cycles(490);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_period", bus.period, 0);
      check("midrst_valid", bus.period_valid, 0);
      check("midrst_in_range", bus.in_range, 0);
      check("midrst_timeout", bus.timeout, 0);
      check("midrst_locked", bus.locked, 0);
      armed    = 1'b0;
      rst_evt++;
      last_neg = cyc;
      rise(200, 1'b0);
      rise(1000, 1'b0);

      // asynchronous edges with sub-cycle offsets
      async_mode = 1'b1;
      repeat (12) rise(1000, 1'b1);

      // final silence
      if (armed) exp_to.push_back(last_eff + 3 + MAX_PERIOD);
      idle_cycles(MAX_PERIOD + 50);
      async_mode = 1'b0;

      check("pending_valids", exp_q.size(), 0);
      check("timeout_count", obs_to.size(), exp_to.size());
      for (int i = 0; i < exp_to.size() && i < obs_to.size(); i++)
         check("timeout_time", obs_to[i], exp_to[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
